alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle instruction sequencer that drives the 64-bit ALU from the initiator side. It fetches 32-bit instruction words from instruction memory and decodes them into the ALU's opcode, operand and address fields. It reads the operands from the register file, holds them stable for the ALU latency, and writes the result back. It sits between instruction memory, the register file and the `alu` block, and is the only agent that issues ALU opcodes, including LOAD/STORE.

## Interface
- `IMEM_AW`, 8, instruction memory address width; PC width.
- `ALU_LAT`, 2, cycles operands/opcode are held before `alu_out` is sampled; legal range 1..15.
- `RESET_PC`, 0, PC value loaded on reset and on every start.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled in IDLE/HALTED.
- `imem_addr` out IMEM_AW: fetch address, equal to `pc`.
- `imem_rd` out 1: fetch request, high only in FETCH.
- `imem_data` in 32: instruction word.
- `imem_valid` in 1: `imem_data` valid this cycle.
- `rf_ra1`, `rf_ra2` out 5: register file read addresses; the register file read is combinational.
- `rf_rd1`, `rf_rd2` in 32: register file read data.
- `alu_opcode` out 5: ALU opcode.
- `alu_address` out 5: ALU memory address field.
- `alu_rg1`, `alu_rg2` out 32: ALU operands, registered.
- `alu_out` in 64: ALU result.
- `rf_we` out 1: register write enable.
- `rf_wa` out 5: register write address.
- `rf_wd` out 32: register write data.
- `pc` out IMEM_AW: current PC.
- `busy` out 1: high in any state except IDLE/HALTED.
- `halted` out 1: high in HALTED.
- `carry` out 1: carry flag.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Instruction format:
  - [31:27] opcode.
  - [26:22] rd.
  - [21:17] rs1.
  - [16:12] rs2.
  - [11:7] addr.
  - [6:0] reserved, ignored.
- Opcodes:
  - ADD 00000, ADC 00001, SUB 00010, SBB 00011, MUL 00100.
  - FADD 00101, FSUB 00110, FMUL 00111.
  - AND 01000, OR 01001, XOR 01010, NAND 01011, NOR 01100, XNOR 01101, NOT 01110, NEG 01111.
  - LOAD 10000, STORE 11000.
  - HALT 11111: not sent to the ALU.
  - Any other code is illegal.
- States: IDLE, FETCH, DECODE, EXEC, WB_LO, WB_HI, HALTED.
- IDLE/HALTED → FETCH when `start`=1; PC loads `RESET_PC`.
- FETCH: `imem_rd`=1 and wait for `imem_valid`. Latch the instruction, then → DECODE.
- DECODE: drive `rf_ra1`=rs1 and `rf_ra2`=rs2, and register `rf_rd1`/`rf_rd2` into `alu_rg1`/`alu_rg2`. Next state:
  - HALT → HALTED; PC is not advanced.
  - Illegal → pulse `illegal`, PC+1, → FETCH.
  - Otherwise → EXEC.
- EXEC: drive the decoded `alu_opcode`/`alu_address` for exactly `ALU_LAT` cycles. On the last cycle, latch `alu_out`. Next state:
  - STORE → PC+1, → FETCH; no writeback.
  - Otherwise → WB_LO.
- WB_LO: `rf_we`=1, `rf_wa`=rd, `rf_wd`=result[31:0].
  - MUL/FMUL → WB_HI.
  - Otherwise PC+1, → FETCH.
- WB_HI: `rf_we`=1, `rf_wa`=(rd+1) mod 32, `rf_wd`=result[63:32]. Then PC+1, → FETCH.
- Carry flag: `carry` ← result[32], updated in WB_LO for ADD/ADC/SUB/SBB/NEG only. All other opcodes leave it unchanged.
- Outside EXEC, `alu_opcode`=ADD (00000), so the ALU is never in STORE except during an issued STORE.
- PC wraps modulo 2^IMEM_AW.
- `start` while `busy` is ignored.
- rd=31 with MUL writes its high word to register 0.

## Timing
- Reset (async, `rst_n`=0) forces, immediately:
  - state=IDLE.
  - `pc`=RESET_PC, `imem_addr`=RESET_PC.
  - `alu_opcode`=0, `alu_address`=0, `alu_rg1`=0, `alu_rg2`=0.
  - `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `rf_ra1`=0, `rf_ra2`=0.
  - `imem_rd`=0, `busy`=0, `halted`=0, `carry`=0, `illegal`=0.
- Reset mid-instruction aborts it with no writeback.
- Cycles per instruction, with `imem_valid` in the first FETCH cycle:
  - Single-word result: 3+ALU_LAT (5 at default).
  - MUL/FMUL: 4+ALU_LAT.
  - STORE: 2+ALU_LAT.
  - Illegal: 2.
  - HALT: 2 cycles to `halted`=1.
- Each cycle `imem_valid` is late extends FETCH by one cycle.
- `imem_valid` outside FETCH is ignored.
- `rf_we` is high at most one cycle per written register.
- `alu_rg1`, `alu_rg2`, `alu_opcode` and `alu_address` are stable for the entire EXEC window.
- `illegal` is high for exactly the DECODE cycle that flags it.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants, including HALT.
  - Instruction field bit positions.
  - State enum.
  - Write-back class enum: NONE/LO/LOHI.
- Sub-module `instr_decode`: combinational. Input: instruction word. Outputs: opcode, rd, rs1, rs2, addr, wb class, carry-update flag, illegal, halt.

## Test plan
- Reset then `start`; imem[0]=ADD rd=3 rs1=1 rs2=2, r1=5, r2=7, `alu_out`=12 → `rf_we` in cycle 5, `rf_wa`=3, `rf_wd`=12, `carry`=0, `pc`=1.
- MUL rd=4, `alu_out`=0x0000_0002_0000_0001 → writes r4=1, then r5=2 in consecutive cycles; total 6 cycles.
- STORE addr=9 rs1=1 → `alu_opcode`=11000 and `alu_address`=9 for exactly 2 cycles; `rf_we` never asserted.
- Opcode 10101, then HALT → `illegal` pulses once, `pc` 0→1; HALT → `halted`=1 with `pc`=1; `start` restarts at 0.
- `imem_valid` delayed 3 cycles; `rst_n` pulsed low during EXEC → FETCH stretches by 3 cycles; after reset, all outputs are at reset values and no writeback occurs.
- PC at 255 (IMEM_AW=8) executing ADD → `pc` wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction fields and state types for the ALU issue controller
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADC   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SBB   = 5'b00011;
  localparam logic [4:0] OP_MUL   = 5'b00100;
  localparam logic [4:0] OP_FADD  = 5'b00101;
  localparam logic [4:0] OP_FSUB  = 5'b00110;
  localparam logic [4:0] OP_FMUL  = 5'b00111;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_OR    = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_NAND  = 5'b01011;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_XNOR  = 5'b01101;
  localparam logic [4:0] OP_NOT   = 5'b01110;
  localparam logic [4:0] OP_NEG   = 5'b01111;
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b11000;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  // Instruction word field positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 22;
  localparam int RS1_MSB  = 21;
  localparam int RS1_LSB  = 17;
  localparam int RS2_MSB  = 16;
  localparam int RS2_LSB  = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB_LO, ST_WB_HI, ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    WB_NONE, WB_LO, WB_LOHI
  } wb_class_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction field split and opcode classification
import alu_pkg::*;

module instr_decode (
  input  logic [31:0] instr,
  output logic [4:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  addr,
  output wb_class_t   wb_class,
  output logic        carry_upd,
  output logic        illegal,
  output logic        halt
);

  // Low seven bits are reserved and deliberately ignored
  logic unused_reserved;
  assign unused_reserved = ^instr[6:0];

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];
  assign addr   = instr[ADDR_MSB:ADDR_LSB];

  // Classify opcode into write-back width, carry behaviour, halt and illegal
  always_comb begin
    wb_class  = WB_LO;
    carry_upd = 1'b0;
    illegal   = 1'b0;
    halt      = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_NEG: carry_upd = 1'b1;
      OP_MUL, OP_FMUL:                        wb_class = WB_LOHI;
      OP_STORE:                               wb_class = WB_NONE;
      OP_HALT: begin
        halt     = 1'b1;
        wb_class = WB_NONE;
      end
      OP_FADD, OP_FSUB, OP_AND, OP_OR, OP_XOR, OP_NAND,
      OP_NOR, OP_XNOR, OP_NOT, OP_LOAD:       wb_class = WB_LO;
      default: begin
        illegal  = 1'b1;
        wb_class = WB_NONE;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle fetch/decode/execute/write-back sequencer driving the ALU
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int                   IMEM_AW  = 8,
  parameter int                   ALU_LAT  = 2,
  parameter logic [IMEM_AW-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_rd,
  input  logic [31:0]        imem_data,
  input  logic               imem_valid,
  output logic [4:0]         rf_ra1,
  output logic [4:0]         rf_ra2,
  input  logic [31:0]        rf_rd1,
  input  logic [31:0]        rf_rd2,
  output logic [4:0]         alu_opcode,
  output logic [4:0]         alu_address,
  output logic [31:0]        alu_rg1,
  output logic [31:0]        alu_rg2,
  input  logic [63:0]        alu_out,
  output logic               rf_we,
  output logic [4:0]         rf_wa,
  output logic [31:0]        rf_wd,
  output logic [IMEM_AW-1:0] pc,
  output logic               busy,
  output logic               halted,
  output logic               carry,
  output logic               illegal
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q;
  logic [31:0]        instr_q;
  logic [31:0]        rg1_q, rg2_q;
  logic [63:0]        result_q;
  logic [3:0]         cnt_q;
  logic               carry_q;
  logic               pc_adv;
  logic               exec_last;

  logic [4:0] d_opcode, d_rd, d_rs1, d_rs2, d_addr;
  wb_class_t  d_wb;
  logic       d_carry_upd, d_illegal, d_halt;

  instr_decode u_decode (
    .instr     (instr_q),
    .opcode    (d_opcode),
    .rd        (d_rd),
    .rs1       (d_rs1),
    .rs2       (d_rs2),
    .addr      (d_addr),
    .wb_class  (d_wb),
    .carry_upd (d_carry_upd),
    .illegal   (d_illegal),
    .halt      (d_halt)
  );

  assign exec_last   = (cnt_q == LAT_M1);
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign alu_rg1     = rg1_q;
  assign alu_rg2     = rg2_q;
  assign carry       = carry_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted      = (state_q == ST_HALTED);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state outputs; the ALU sees ADD whenever nothing is issued
  always_comb begin
    state_d     = state_q;
    pc_adv      = 1'b0;
    imem_rd     = 1'b0;
    rf_ra1      = 5'd0;
    rf_ra2      = 5'd0;
    alu_opcode  = OP_ADD;
    alu_address = 5'd0;
    rf_we       = 1'b0;
    rf_wa       = 5'd0;
    rf_wd       = 32'd0;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_rd = 1'b1;
        if (imem_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        rf_ra1 = d_rs1;
        rf_ra2 = d_rs2;
        if (d_halt) begin
          state_d = ST_HALTED;
        end else if (d_illegal) begin
          illegal = 1'b1;
          pc_adv  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_opcode  = d_opcode;
        alu_address = d_addr;
        if (exec_last) begin
          if (d_wb == WB_NONE) begin
            pc_adv  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB_LO;
          end
        end
      end
      ST_WB_LO: begin
        rf_we = 1'b1;
        rf_wa = d_rd;
        rf_wd = result_q[31:0];
        if (d_wb == WB_LOHI) begin
          state_d = ST_WB_HI;
        end else begin
          pc_adv  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB_HI: begin
        rf_we   = 1'b1;
        rf_wa   = d_rd + 5'd1;
        rf_wd   = result_q[63:32];
        pc_adv  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: PC, instruction latch, operand hold, latency counter, result and carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      rg1_q    <= 32'd0;
      rg2_q    <= 32'd0;
      result_q <= 64'd0;
      cnt_q    <= 4'd0;
      carry_q  <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE || state_q == ST_HALTED) && start) pc_q <= RESET_PC;
      else if (pc_adv)                                          pc_q <= pc_q + IMEM_AW'(1);
      if (state_q == ST_FETCH && imem_valid) instr_q <= imem_data;
      if (state_q == ST_DECODE) begin
        rg1_q <= rf_rd1;
        rg2_q <= rf_rd2;
      end
      if (state_q == ST_EXEC) begin
        cnt_q <= exec_last ? 4'd0 : cnt_q + 4'd1;
        if (exec_last) result_q <= alu_out;
      end else begin
        cnt_q <= 4'd0;
      end
      if (state_q == ST_WB_LO && d_carry_upd) carry_q <= result_q[32];
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  localparam int LAT = 2;

  logic        clk, rst_n, start;
  logic [7:0]  imem_addr, pc;
  logic        imem_rd, imem_valid;
  logic [31:0] imem_data, rf_rd1, rf_rd2, alu_rg1, alu_rg2, rf_wd;
  logic [4:0]  rf_ra1, rf_ra2, alu_opcode, alu_address, rf_wa;
  logic [63:0] alu_out;
  logic        rf_we, busy, halted, carry, illegal;

  int checks = 0;
  int failures = 0;

  logic [31:0] imem [256];
  logic [31:0] regs [32];
  int          fetch_wait = 0;
  int          valid_delay = 0;

  int mon_we = 0, mon_ill = 0, mon_store = 0, mon_rd = 0;

  alu_issue_ctrl #(.IMEM_AW(8), .ALU_LAT(LAT), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data), .imem_valid(imem_valid),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_opcode(alu_opcode), .alu_address(alu_address), .alu_rg1(alu_rg1), .alu_rg2(alu_rg2),
    .alu_out(alu_out), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pc(pc), .busy(busy), .halted(halted), .carry(carry), .illegal(illegal)
  );

  function automatic logic [31:0] enc(input logic [4:0] op, rd, r1, r2, ad);
    return {op, rd, r1, r2, ad, 7'h5A};
  endfunction

  function automatic logic [31:0] init_reg(input int i);
    case (i)
      1: return 32'd5;
      2: return 32'd7;
      6: return 32'd3;
      7: return 32'hAAAA_AAAB;
      default: return 32'h100 + 32'(i);
    endcase
  endfunction

  // Stand-in ALU: arithmetic meaning of each opcode, 64-bit result
  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, b);
    case (op)
      5'd0, 5'd1:  return {32'h0, a} + {32'h0, b};
      5'd2, 5'd3:  return {32'h0, a} - {32'h0, b};
      5'd4, 5'd7:  return {32'h0, a} * {32'h0, b};
      5'd8:        return {32'h0, a & b};
      5'd15:       return 64'h0 - {32'h0, a};
      default:     return {b, a ^ b};
    endcase
  endfunction

  assign imem_data  = imem[imem_addr];
  assign rf_rd1     = regs[rf_ra1];
  assign rf_rd2     = regs[rf_ra2];
  assign alu_out    = alu_f(alu_opcode, alu_rg1, alu_rg2);
  assign imem_valid = imem_rd && (fetch_wait > valid_delay);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file stand-in: preload then accept DUT writes
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = init_reg(i);
    forever begin
      @(posedge clk);
      if (rf_we) regs[rf_wa] = rf_wd;
    end
  end

  // Counts FETCH cycles so imem_valid can be held off for valid_delay cycles
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (imem_rd) fetch_wait = fetch_wait + 1;
      else         fetch_wait = 0;
    end
  end

  // Event counters used by the directed checks
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we)              mon_we++;
      if (illegal)            mon_ill++;
      if (alu_opcode == 5'd24) mon_store++;
      if (imem_rd)            mon_rd++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model: expected per-cycle trace per instruction ----------------
  typedef struct packed {
    logic        ird, bsy, hlt, ill, we, chk_w, chk_ra, chk_rg, car;
    logic [4:0]  opc, adr, wa, ra1, ra2;
    logic [31:0] wd, rg1, rg2;
    logic [7:0]  pc;
  } exp_t;

  exp_t        cur, m_next;
  exp_t        q [$];
  logic        m_carry;
  logic [31:0] m_regs [32];

  function automatic exp_t base(input logic [7:0] p, input logic c);
    exp_t e;
    e     = '0;
    e.pc  = p;
    e.car = c;
    e.bsy = 1'b1;
    return e;
  endfunction

  function automatic exp_t fetch_rec(input logic [7:0] p, input logic c);
    exp_t e;
    e     = base(p, c);
    e.ird = 1'b1;
    return e;
  endfunction

  task automatic build(input logic [7:0] p);
    logic [31:0] w, a, b;
    logic [63:0] r;
    logic [4:0]  op, rd, s1, s2, ad;
    exp_t        e;
    w  = imem[p];
    op = w[31:27]; rd = w[26:22]; s1 = w[21:17]; s2 = w[16:12]; ad = w[11:7];
    e = base(p, m_carry);
    e.chk_ra = 1'b1; e.ra1 = s1; e.ra2 = s2;
    if (op == 5'd31) begin
      q.push_back(e);
      m_next = base(p, m_carry);
      m_next.bsy = 1'b0;
      m_next.hlt = 1'b1;
    end else if (!(op <= 5'd15 || op == 5'd16 || op == 5'd24)) begin
      e.ill = 1'b1;
      q.push_back(e);
      m_next = fetch_rec(p + 8'd1, m_carry);
    end else begin
      q.push_back(e);
      a = m_regs[s1];
      b = m_regs[s2];
      r = alu_f(op, a, b);
      e = base(p, m_carry);
      e.opc = op; e.adr = ad; e.chk_rg = 1'b1; e.rg1 = a; e.rg2 = b;
      for (int i = 0; i < LAT; i++) q.push_back(e);
      if (op != 5'd24) begin
        e = base(p, m_carry);
        e.we = 1'b1; e.chk_w = 1'b1; e.wa = rd; e.wd = r[31:0];
        q.push_back(e);
        if (op <= 5'd3 || op == 5'd15) m_carry = r[32];
        if (op == 5'd4 || op == 5'd7) begin
          e = base(p, m_carry);
          e.we = 1'b1; e.chk_w = 1'b1; e.wa = rd + 5'd1; e.wd = r[63:32];
          q.push_back(e);
        end
      end
      m_next = fetch_rec(p + 8'd1, m_carry);
    end
  endtask

  // Compare DUT against the model every cycle, then step the model
  initial begin
    exp_t nx;
    for (int i = 0; i < 32; i++) m_regs[i] = init_reg(i);
    m_carry = 1'b0;
    cur = base(8'd0, 1'b0);
    cur.bsy = 1'b0;
    m_next = cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_carry = 1'b0;
        cur = base(8'd0, 1'b0);
        cur.bsy = 1'b0; cur.chk_w = 1'b1; cur.chk_ra = 1'b1; cur.chk_rg = 1'b1;
      end
      chk("pc", pc, cur.pc);
      chk("imem_addr", imem_addr, cur.pc);
      chk("imem_rd", imem_rd, cur.ird);
      chk("busy", busy, cur.bsy);
      chk("halted", halted, cur.hlt);
      chk("illegal", illegal, cur.ill);
      chk("alu_opcode", alu_opcode, cur.opc);
      chk("alu_address", alu_address, cur.adr);
      chk("rf_we", rf_we, cur.we);
      chk("carry", carry, cur.car);
      if (cur.chk_w)  begin chk("rf_wa", rf_wa, cur.wa); chk("rf_wd", rf_wd, cur.wd); end
      if (cur.chk_ra) begin chk("rf_ra1", rf_ra1, cur.ra1); chk("rf_ra2", rf_ra2, cur.ra2); end
      if (cur.chk_rg) begin chk("alu_rg1", alu_rg1, cur.rg1); chk("alu_rg2", alu_rg2, cur.rg2); end
      if (cur.we) m_regs[cur.wa] = cur.wd;
      if (rst_n) begin
        if (cur.ird) begin
          if (imem_valid) begin
            build(cur.pc);
            cur = q.pop_front();
          end
        end else if (q.size() != 0) begin
          cur = q.pop_front();
        end else if (cur.bsy) begin
          cur = m_next;
        end else if (start) begin
          cur = fetch_rec(8'd0, m_carry);
        end else begin
          nx = base(cur.pc, m_carry);
          nx.bsy = 1'b0;
          nx.hlt = cur.hlt;
          cur = nx;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int hc, output int we_c,
                             output logic [4:0] wa, output logic [31:0] wd);
    int k;
    k = 1; we_c = 0; wa = 0; wd = 0;
    while (!halted && k < budget) begin
      if (rf_we && we_c == 0) begin we_c = k; wa = rf_wa; wd = rf_wd; end
      @(posedge clk); #1;
      k++;
    end
    hc = k;
    chk("halt_reached", halted, 1'b1);
  endtask

  initial begin
    int hc, we_c, k, we0, ill0, st0, rd0;
    logic [4:0]  wa;
    logic [31:0] wd;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
    imem[0] = enc(5'd0,  5'd3, 5'd1, 5'd2, 5'd0);
    imem[1] = enc(5'd4,  5'd4, 5'd6, 5'd7, 5'd0);
    imem[2] = enc(5'd24, 5'd0, 5'd1, 5'd2, 5'd9);
    imem[3] = enc(5'd2,  5'd8, 5'd1, 5'd2, 5'd0);
    imem[4] = enc(5'd8,  5'd9, 5'd1, 5'd2, 5'd0);
    imem[5] = enc(5'd31, 5'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_opcode", alu_opcode, 5'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Program: ADD, MUL, STORE, SUB, AND, HALT
    we0 = mon_we; st0 = mon_store;
    pulse_start();
    run_to_halt(100, hc, we_c, wa, wd);
    chk("add_wb_cycle", we_c, 5);
    chk("add_wa", wa, 5'd3);
    chk("add_wd", wd, 32'd12);
    chk("prog1_halt_cycle", hc, 28);
    chk("prog1_pc", pc, 8'd5);
    chk("mul_lo_r4", regs[4], 32'd1);
    chk("mul_hi_r5", regs[5], 32'd2);
    chk("sub_r8", regs[8], 32'hFFFF_FFFE);
    chk("and_r9", regs[9], 32'd5);
    chk("carry_after_sub_and", carry, 1'b1);
    chk("store_cycles", mon_store - st0, 2);
    chk("we_count", mon_we - we0, 5);

    // Illegal then HALT, then restart
    imem[0] = enc(5'b10101, 5'd3, 5'd1, 5'd2, 5'd0);
    imem[1] = enc(5'd31, 5'd0, 5'd0, 5'd0, 5'd0);
    ill0 = mon_ill;
    pulse_start();
    run_to_halt(50, hc, we_c, wa, wd);
    chk("illegal_pulses", mon_ill - ill0, 1);
    chk("halt_pc", pc, 8'd1);
    chk("illegal_halt_cycle", hc, 5);
    pulse_start();
    chk("restart_pc", pc, 8'd0);
    chk("restart_busy", busy, 1'b1);
    run_to_halt(50, hc, we_c, wa, wd);

    // Late imem_valid, then reset during EXEC of a MUL
    imem[0] = enc(5'd4, 5'd20, 5'd6, 5'd7, 5'd0);
    valid_delay = 3;
    we0 = mon_we; rd0 = mon_rd;
    pulse_start();
    k = 1;
    while (alu_opcode != 5'd4 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("late_exec_cycle", k, 6);
    chk("late_fetch_cycles", mon_rd - rd0, 4);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_opcode", alu_opcode, 5'd0);
    chk("abort_rg1", alu_rg1, 32'd0);
    chk("abort_carry", carry, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_delay = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_wb", mon_we - we0, 0);
    chk("abort_r20", regs[20], 32'h114);
    chk("abort_idle", busy, 1'b0);

    // PC wrap: illegal filler up to 255, ADD at 255, HALT at 0 after wrap
    for (int i = 0; i < 255; i++) imem[i] = enc(5'b10110, 5'd0, 5'd0, 5'd0, 5'd0);
    imem[255] = enc(5'd0, 5'd10, 5'd1, 5'd2, 5'd0);
    pulse_start();
    k = 0;
    while (pc != 8'd255 && k < 700) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_pc255", pc, 8'd255);
    imem[0] = enc(5'd31, 5'd0, 5'd0, 5'd0, 5'd0);
    run_to_halt(40, hc, we_c, wa, wd);
    chk("wrap_pc", pc, 8'd0);
    chk("wrap_r10", regs[10], 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
